// File: rtl/soc_bus_arb_pkg.sv
// Shared types and defaults for the SoC bus arbiter: FSM state encoding and timeout default.
package soc_bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam int unsigned TimeoutCycDefault = 255;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_arb_if.sv
// Bundle of upstream master-side and downstream memory-side signals around the bus arbiter.
interface soc_bus_arb_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [NM-1:0]    m_stb;
  logic [NM-1:0]    m_rw;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_dtw;
  logic [NM-1:0]    m_lock;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_dtr;
  logic [NM-1:0]    grant;
  logic             s_stb;
  logic             s_rw;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_dtw;
  logic             s_ack;
  logic [DW-1:0]    s_dtr;

  // Arbiter view: it serves the masters and drives the downstream request.
  modport slave (
    input  m_stb, m_rw, m_addr, m_dtw, m_lock, s_ack, s_dtr,
    output m_ack, m_err, m_dtr, grant, s_stb, s_rw, s_addr, s_dtw
  );

  modport master (
    output m_stb, m_rw, m_addr, m_dtw, m_lock, s_ack, s_dtr,
    input  m_ack, m_err, m_dtr, grant, s_stb, s_rw, s_addr, s_dtw
  );
endinterface

// File: rtl/soc_rr_pick.sv
// Combinational round-robin picker: first requester after index `last`, wrapping around.
module soc_rr_pick #(
  parameter int unsigned NM = 2,
  parameter int unsigned LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] win,
  output logic [LW-1:0] win_idx
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NM; off++) begin
      idx = LW'((32'(last) + off) % NM);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_arb.sv
// Round-robin multi-master arbiter for the SoC memory bus with per-master lock.
// Optional downstream wait timeout enabled by defining SOC_ARB_TIMEOUT_EN.
module soc_bus_arb
  import soc_bus_arb_pkg::*;
#(
  parameter int unsigned NM          = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input logic          clk,
  input logic          rst_n,
  soc_bus_arb_if.slave bus
);

  localparam int unsigned LW = idx_width(NM);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] pend_q, pend_d, accept, ack;
  logic [NM-1:0] grant_q, grant_n, pick_req, win;
  logic [LW-1:0] last_q, sel_idx, win_idx;
  logic          load, timeout;
  logic [AW-1:0] hold_addr [NM];
  logic [DW-1:0] hold_dtw  [NM];
  logic [NM-1:0] hold_rw;
  logic [AW-1:0] sel_addr, s_addr_q;
  logic [DW-1:0] sel_dtw, s_dtw_q, m_dtr_q;
  logic          sel_rw, s_rw_q;

  // The winner's pend clears on its ack; a new strobe in that same cycle wins.
  assign ack      = grant_q & {NM{state_q == StDone}};
  assign accept   = bus.m_stb & (~pend_q | ack);
  assign pend_d   = accept | (pend_q & ~ack);
  assign pick_req = (state_q == StDone) ? pend_d : pend_q;

  soc_rr_pick #(
    .NM (NM),
    .LW (LW)
  ) u_pick (
    .req     (pick_req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // DONE chains straight into the next grant so queued requests see one-cycle turnaround.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sel_idx = win_idx;
    grant_n = win;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StIssue;
          load    = 1'b1;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.s_ack || timeout) state_d = StDone;
      end
      StDone: begin
        if (bus.m_lock[last_q] && accept[last_q]) begin
          state_d = StIssue;
          load    = 1'b1;
          sel_idx = last_q;
          grant_n = grant_q;
        end else if (|pend_d) begin
          state_d = StIssue;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request captured this very cycle is taken straight from the master inputs.
  always_comb begin
    if (accept[sel_idx]) begin
      sel_addr = bus.m_addr[32'(sel_idx)*AW +: AW];
      sel_dtw  = bus.m_dtw[32'(sel_idx)*DW +: DW];
      sel_rw   = bus.m_rw[sel_idx];
    end else begin
      sel_addr = hold_addr[sel_idx];
      sel_dtw  = hold_dtw[sel_idx];
      sel_rw   = hold_rw[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      last_q   <= LW'(NM - 1);
      grant_q  <= '0;
      s_addr_q <= '0;
      s_dtw_q  <= '0;
      s_rw_q   <= 1'b0;
      m_dtr_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (load) begin
        last_q   <= sel_idx;
        grant_q  <= grant_n;
        s_addr_q <= sel_addr;
        s_dtw_q  <= sel_dtw;
        s_rw_q   <= sel_rw;
      end else if (state_d == StIdle) begin
        grant_q <= '0;
      end
      if (state_q == StWait && (bus.s_ack || timeout)) begin
        m_dtr_q <= timeout ? '0 : bus.s_dtr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NM; i++) begin
        hold_addr[i] <= '0;
        hold_dtw[i]  <= '0;
      end
      hold_rw <= '0;
    end else begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (accept[i]) begin
          hold_addr[i] <= bus.m_addr[i*AW +: AW];
          hold_dtw[i]  <= bus.m_dtw[i*DW +: DW];
          hold_rw[i]   <= bus.m_rw[i];
        end
      end
    end
  end

`ifdef SOC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Fires on the cycle the count would reach TIMEOUT_CYC, so DONE lands TIMEOUT_CYC+1 after ISSUE.
  assign timeout = (state_q == StWait) && !bus.s_ack && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == StWait) ? cnt_q + CW'(1) : '0;
      if (state_q == StWait) err_q <= timeout;
    end
  end

  assign bus.m_err = ack & {NM{err_q}};
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
  assign bus.m_err          = '0;
`endif

  assign bus.m_ack  = ack;
  assign bus.m_dtr  = m_dtr_q;
  assign bus.grant  = grant_q;
  assign bus.s_stb  = (state_q == StIssue);
  assign bus.s_addr = s_addr_q;
  assign bus.s_dtw  = s_dtw_q;
  assign bus.s_rw   = s_rw_q;

endmodule

// File: tb/tb_soc_bus_arb.sv
// Directed bench for soc_bus_arb: per-cycle vector table plus reset and timeout sequences.
module tb_soc_bus_arb;

  localparam logic [31:0] G = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  soc_bus_arb_if #(.NM(2), .AW(32), .DW(32)) bus ();

  soc_bus_arb #(
    .NM          (2),
    .AW          (32),
    .DW          (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  stb, rw, lock;
    logic [31:0] a0, a1, d0, d1;
    logic        sack;
    logic [31:0] sdtr;
  } in_t;

  typedef struct {
    logic        sstb;
    logic [1:0]  gnt, ack;
    logic [31:0] addr, dtw;
    logic        rw;
    logic [31:0] dtr;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

  vec_t tbl[$];

  function automatic in_t rq(input logic [1:0] stb, rw, lock,
                             input logic [31:0] a0, a1, d0, d1,
                             input logic sack, input logic [31:0] sdtr);
    in_t r;
    r.stb = stb; r.rw = rw; r.lock = lock;
    r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.sack = sack; r.sdtr = sdtr;
    return r;
  endfunction

  function automatic in_t nop(input logic sack, input logic [31:0] sdtr);
    return rq(2'b00, 2'b00, 2'b00, G, G, G, G, sack, sdtr);
  endfunction

  function automatic ex_t ex(input logic sstb, input logic [1:0] gnt, ack,
                             input logic [31:0] addr, dtw, input logic rw,
                             input logic [31:0] dtr);
    ex_t r;
    r.sstb = sstb; r.gnt = gnt; r.ack = ack;
    r.addr = addr; r.dtw = dtw; r.rw = rw; r.dtr = dtr;
    return r;
  endfunction

  function automatic ex_t ex_idle();
    return ex(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 0);
  endfunction

  task automatic add(input in_t i, input ex_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    bus.m_stb  = i.stb;
    bus.m_rw   = i.rw;
    bus.m_lock = i.lock;
    bus.m_addr = {i.a1, i.a0};
    bus.m_dtw  = {i.d1, i.d0};
    bus.s_ack  = i.sack;
    bus.s_dtr  = i.sdtr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(nop(1'b0, 0));

    // Contention from reset: master 0 first, master 1 one cycle after m_ack[0].
    add(rq(2'b11, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'hA0, 32'hB1, 0, 0), ex_idle());
    add(nop(0, 0), ex_idle());
    add(nop(0, 0), ex(1, 2'b01, 2'b00, 32'h1000, 32'hA0, 1, 0));
    add(nop(1, 32'h55), ex(0, 2'b01, 2'b00, 32'h1000, 32'hA0, 1, 0));
    add(nop(0, 0), ex(0, 2'b01, 2'b01, 32'h1000, 32'hA0, 1, 32'h55));
    add(nop(0, 0), ex(1, 2'b10, 2'b00, 32'h2000, 32'hB1, 1, 0));
    add(nop(0, 0), ex(0, 2'b10, 2'b00, 32'h2000, 32'hB1, 1, 0));
    add(nop(1, 32'h77), ex(0, 2'b10, 2'b00, 32'h2000, 32'hB1, 1, 0));
    add(nop(0, 0), ex(0, 2'b10, 2'b10, 32'h2000, 32'hB1, 1, 32'h77));
    add(nop(1, 32'hBAD), ex_idle());
    // Single CPU read; stray s_ack while idle must be ignored.
    add(rq(2'b01, 2'b00, 2'b00, 32'h100, G, 0, G, 1, 32'hBAD), ex_idle());
    add(nop(1, 32'hBAD), ex_idle());
    add(nop(0, 0), ex(1, 2'b01, 2'b00, 32'h100, 0, 0, 0));
    add(nop(1, 32'h1234_5678), ex(0, 2'b01, 2'b00, 32'h100, 0, 0, 0));
    add(nop(0, 0), ex(0, 2'b01, 2'b01, 32'h100, 0, 0, 32'h1234_5678));
    add(nop(0, 0), ex_idle());
    // Lock: master 1 re-strobes in DONE with lock held while master 0 waits.
    add(rq(2'b10, 2'b10, 2'b10, G, 32'h3000, G, 32'h31, 0, 0), ex_idle());
    add(nop(0, 0), ex_idle());
    add(rq(2'b01, 2'b00, 2'b10, 32'h4000, G, 32'h40, G, 0, 0),
        ex(1, 2'b10, 2'b00, 32'h3000, 32'h31, 1, 0));
    add(nop(0, 0), ex(0, 2'b10, 2'b00, 32'h3000, 32'h31, 1, 0));
    add(nop(1, 0), ex(0, 2'b10, 2'b00, 32'h3000, 32'h31, 1, 0));
    add(rq(2'b10, 2'b10, 2'b10, G, 32'h3004, G, 32'h32, 0, 0),
        ex(0, 2'b10, 2'b10, 32'h3000, 32'h31, 1, 0));
    add(nop(0, 0), ex(1, 2'b10, 2'b00, 32'h3004, 32'h32, 1, 0));
    add(nop(1, 32'h5A), ex(0, 2'b10, 2'b00, 32'h3004, 32'h32, 1, 0));
    add(nop(0, 0), ex(0, 2'b10, 2'b10, 32'h3004, 32'h32, 1, 32'h5A));
    add(nop(0, 0), ex(1, 2'b01, 2'b00, 32'h4000, 32'h40, 0, 0));
    add(nop(1, 32'hCAFE), ex(0, 2'b01, 2'b00, 32'h4000, 32'h40, 0, 0));
    add(nop(0, 0), ex(0, 2'b01, 2'b01, 32'h4000, 32'h40, 0, 32'hCAFE));
    add(nop(0, 0), ex_idle());
    // Dropped re-strobes while pending; s_ack during ISSUE ignored.
    add(rq(2'b01, 2'b00, 2'b00, 32'h180, G, 32'h18, G, 0, 0), ex_idle());
    add(rq(2'b01, 2'b01, 2'b00, 32'h200, G, 32'h20, G, 0, 0), ex_idle());
    add(rq(2'b01, 2'b01, 2'b00, 32'h300, G, 32'h30, G, 1, 32'hBAD),
        ex(1, 2'b01, 2'b00, 32'h180, 32'h18, 0, 0));
    add(nop(0, 0), ex(0, 2'b01, 2'b00, 32'h180, 32'h18, 0, 0));
    add(nop(1, 32'h99), ex(0, 2'b01, 2'b00, 32'h180, 32'h18, 0, 0));
    add(nop(0, 0), ex(0, 2'b01, 2'b01, 32'h180, 32'h18, 0, 32'h99));
    add(nop(0, 0), ex_idle());
    add(nop(0, 0), ex_idle());

    #12;
    chk("rst_s_stb", 32'(bus.s_stb), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_m_ack", 32'(bus.m_ack), 0);
    chk("rst_m_err", 32'(bus.m_err), 0);
    chk("rst_m_dtr", bus.m_dtr, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_dtw", bus.s_dtw, 0);
    chk("rst_s_rw", 32'(bus.s_rw), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      drive(tbl[k].i);
      #1;
      chk($sformatf("v%0d_s_stb", k), 32'(bus.s_stb), 32'(tbl[k].e.sstb));
      chk($sformatf("v%0d_grant", k), 32'(bus.grant), 32'(tbl[k].e.gnt));
      chk($sformatf("v%0d_m_ack", k), 32'(bus.m_ack), 32'(tbl[k].e.ack));
      if (tbl[k].e.gnt != 2'b00) begin
        chk($sformatf("v%0d_s_addr", k), bus.s_addr, tbl[k].e.addr);
        chk($sformatf("v%0d_s_dtw", k), bus.s_dtw, tbl[k].e.dtw);
        chk($sformatf("v%0d_s_rw", k), 32'(bus.s_rw), 32'(tbl[k].e.rw));
      end
      if (tbl[k].e.ack != 2'b00) begin
        chk($sformatf("v%0d_m_dtr", k), bus.m_dtr, tbl[k].e.dtr);
        chk($sformatf("v%0d_m_err", k), 32'(bus.m_err), 0);
      end
    end

    // Async reset while in WAIT.
    @(posedge clk); #1;
    drive(rq(2'b01, 2'b00, 2'b00, 32'h500, G, 32'h55, G, 0, 0));
    @(posedge clk); #1;
    drive(nop(0, 0));
    n = 1;
    #1;
    while (bus.s_stb !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("ar_issue_latency", n, 2);
    @(posedge clk); #3;
    chk("ar_wait_grant", 32'(bus.grant), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_async_grant", 32'(bus.grant), 0);
    chk("ar_async_s_stb", 32'(bus.s_stb), 0);
    chk("ar_async_m_ack", 32'(bus.m_ack), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      chk("ar_no_stale", {29'd0, bus.s_stb, bus.m_ack}, 0);
    end
    @(posedge clk); #1;
    drive(rq(2'b10, 2'b10, 2'b00, G, 32'h600, G, 32'h66, 0, 0));
    @(posedge clk); #1;
    drive(nop(0, 0));
    n = 1;
    #1;
    while (bus.s_stb !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("ar_new_latency", n, 2);
    chk("ar_new_grant", 32'(bus.grant), 32'h2);
    chk("ar_new_s_addr", bus.s_addr, 32'h600);
    chk("ar_new_s_dtw", bus.s_dtw, 32'h66);
    @(posedge clk); #1;
    drive(nop(1, 32'hABCD));
    @(posedge clk); #1;
    drive(nop(0, 0));
    #1;
    chk("ar_new_m_ack", 32'(bus.m_ack), 32'h2);
    chk("ar_new_m_dtr", bus.m_dtr, 32'hABCD);
    chk("ar_new_m_err", 32'(bus.m_err), 0);

`ifdef SOC_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    drive(rq(2'b01, 2'b00, 2'b00, 32'h700, G, 0, G, 0, 0));
    @(posedge clk); #1;
    drive(nop(0, 0));
    n = 1;
    #1;
    while (bus.s_stb !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("to_issue_latency", n, 2);
    n = 0;
    while (bus.m_ack === 2'b00 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("to_ack_latency", n, 9);
    chk("to_m_ack", 32'(bus.m_ack), 32'h1);
    chk("to_m_err", 32'(bus.m_err), 32'h1);
    chk("to_m_dtr", bus.m_dtr, 0);
    @(posedge clk); #1;
    drive(nop(1, 32'h1111));
    @(posedge clk); #1;
    drive(nop(0, 0));
    repeat (3) begin
      #1;
      chk("to_late_ack", 32'(bus.m_ack), 0);
      @(posedge clk); #1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
